// File: rtl/xadc_pkg.sv
// Shared XADC DRP definitions: bus widths, channel addresses and the arbiter state type.
package xadc_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  localparam logic [DRP_ADDR_W-1:0] TEMP_ADDR   = 7'h00;
  localparam logic [DRP_ADDR_W-1:0] VAUX15_ADDR = 7'h1F;
  localparam logic [DRP_ADDR_W-1:0] CFG0_ADDR   = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RDY,
    RESP
  } drp_arb_state_t;

endpackage

// File: rtl/drp_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo NUM_REQ.
module drp_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  always_comb begin
    logic [PTR_W:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One spare bit holds ptr+i before the modulo fold.
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!valid && req[idx[PTR_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port between NUM_REQ requesters, with drdy watchdog.
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = DRP_ADDR_W,
  parameter int DATA_W         = DRP_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      drp_den,
  output logic                      drp_dwe,
  output logic [ADDR_W-1:0]         drp_daddr,
  output logic [DATA_W-1:0]         drp_di,
  input  logic [DATA_W-1:0]         drp_do,
  input  logic                      drp_drdy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  drp_arb_state_t state, state_nxt;

  logic [PW-1:0]     ptr, win_q, pick;
  logic              pick_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              err_q;
  logic [CW-1:0]     cnt;

  drp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pick_valid) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_RDY;
      WAIT_RDY: if (drp_drdy || cnt == CNT_LAST) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_q   <= pick;
            addr_q  <= addr[pick*ADDR_W +: ADDR_W];
            wdata_q <= wdata[pick*DATA_W +: DATA_W];
            we_q    <= we[pick];
          end
        end
        ISSUE: cnt <= '0;
        WAIT_RDY: begin
          // drdy on the limit cycle still wins over the timeout.
          if (drp_drdy) begin
            err_q <= 1'b0;
            if (!we_q) rdata <= drp_do;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: ptr <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    err = '0;
    if (state == RESP) begin
      ack[win_q] = 1'b1;
      err[win_q] = err_q;
    end
  end

  assign busy      = (state != IDLE);
  assign drp_den   = (state == ISSUE);
  assign drp_dwe   = we_q;
  assign drp_daddr = addr_q;
  assign drp_di    = wdata_q;

endmodule
